gate_truth_checker: RTL and testbench
=====================================

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum number of cycles spent in RUN before the block forces DONE.
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port start, input, 1: one-cycle pulse that begins a check run.
REQ-006 Port vld, input, 1: a, b and y hold a vector to be checked this cycle.
REQ-007 Port a, input, 1: first operand applied to the gate DUT.
REQ-008 Port b, input, 1: second operand applied to the gate DUT.
REQ-009 Port y, input, 7: DUT outputs, bit mapping y[0]=AND, y[1]=OR, y[2]=NAND, y[3]=NOR, y[4]=XOR, y[5]=XNOR, y[6]=NOT a.
REQ-010 Port busy, output, 1: high while in RUN.
REQ-011 Port done, output, 1: high while in DONE.
REQ-012 Port pass, output, 1: verdict, valid only while done=1.
REQ-013 Port err_cnt, output, ERR_W: count of mismatching vectors.
REQ-014 Port cov, output, 4: coverage bitmap, where bit {a,b} is set once that combination has been checked.
REQ-015 Port fail_vec, output, 2: {a,b} of the first mismatching vector.
REQ-016 Port fail_mask, output, 7: y XOR expected for the first mismatching vector.

Function
REQ-017 The FSM has states IDLE, RUN and DONE.
- IDLE to RUN on start.
- DONE to RUN on start.
- RUN ignores start.
REQ-018 On entering RUN from any state, the block clears err_cnt, cov, fail_vec, fail_mask and the timeout counter in the same edge.
REQ-019 In RUN with vld=1, on the next edge the block:
- computes expected outputs from (a,b);
- sets cov[{a,b}];
- increments err_cnt when (y XOR expected) is nonzero.
Latency is 1 cycle from the vld sample to the updated outputs.
REQ-020 err_cnt saturates at 2^ERR_W-1 and never wraps.
REQ-021 fail_vec and fail_mask capture only the first mismatch of a run; later mismatches leave them unchanged.
REQ-022 Repeated vectors re-check and may add errors; cov is unaffected by repeats.
REQ-023 vld is ignored in IDLE and in DONE.
REQ-024 vld is ignored in the cycle start is accepted.
REQ-025 RUN goes to DONE on the edge where cov becomes 4'hF, including the update from the vector sampled in that cycle.
REQ-026 The timeout counter increments every RUN cycle; when it reaches TIMEOUT-1 without full coverage, RUN goes to DONE.
REQ-027 When coverage completes and the timeout expires in the same cycle, coverage completion takes priority and pass is evaluated normally.
REQ-028 pass is 1 iff cov=4'hF and err_cnt=0 at DONE entry; pass holds until the next start or rst.
REQ-029 busy and done are decoded directly from the state register; they are never both high.

Reset
REQ-030 rst has priority over start and vld.
REQ-031 On rst the state becomes IDLE and the following outputs go to 0 on the next edge:
- busy, done, pass;
- err_cnt, cov, fail_vec, fail_mask.
REQ-032 rst asserted mid-RUN abandons the run with no verdict; done stays 0.

Structure
REQ-033 Shared package gate_chk_pkg holds:
- the state enum;
- the y bit-index constants for AND through NOT;
- the default TIMEOUT and ERR_W values.
REQ-034 Sub-module gate_ref_model, purely combinational, maps (a,b) to the 7-bit expected vector; gate_truth_checker instantiates it once.
REQ-035 The implementation is 120-400 lines of RTL with no latches.

Verification
REQ-036 Exhaustive pass run:
- stimulus: start, then correct vectors (0,0), (0,1), (1,0), (1,1) on consecutive cycles;
- response: cov=4'hF, done=1 one cycle after the last vector, pass=1, err_cnt=0.
REQ-037 Faulty XOR:
- stimulus: start, then vector (1,1) with y[4]=1, other bits correct, then the remaining three combinations correct;
- response: err_cnt=1, fail_vec=2'b11, fail_mask=7'b0010000, pass=0.
REQ-038 Timeout:
- stimulus: start, then only (0,0) and (0,1) applied, TIMEOUT=8;
- response: done=1 eight cycles after start is accepted, cov=4'b0011, pass=0.
REQ-039 Reset mid-run:
- stimulus: rst asserted for one cycle after two vectors;
- response: state IDLE, all outputs 0.
- follow-up: vld alone after reset, with no start, leaves cov=0.
REQ-040 Saturation and restart:
- stimulus: ERR_W=2, five wrong (0,0) vectors;
- response: err_cnt holds at 3.
- follow-up: start issued from DONE clears all stats on the next edge.
REQ-041 Coincident timeout and completion:
- stimulus: the last missing vector arrives in the cycle the timeout counter reaches TIMEOUT-1;
- response: done=1, pass=1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth checker: FSM states, y bit
// positions and default parameter values.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions of each gate result within the 7-bit y vector
  localparam int Y_AND  = 0;
  localparam int Y_OR   = 1;
  localparam int Y_NAND = 2;
  localparam int Y_NOR  = 3;
  localparam int Y_XOR  = 4;
  localparam int Y_XNOR = 5;
  localparam int Y_NOT  = 6;
  localparam int Y_W    = 7;

  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_ERR_W   = 8;

endpackage

// File: rtl/gate_ref_model.sv
// Golden combinational model: maps operands (a,b) to the expected gate outputs.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic           i_a,
  input  logic           i_b,
  output logic [Y_W-1:0] o_exp
);

  // Reference truth table, one bit per gate
  always_comb begin
    o_exp         = '0;
    o_exp[Y_AND]  = i_a & i_b;
    o_exp[Y_OR]   = i_a | i_b;
    o_exp[Y_NAND] = ~(i_a & i_b);
    o_exp[Y_NOR]  = ~(i_a | i_b);
    o_exp[Y_XOR]  = i_a ^ i_b;
    o_exp[Y_XNOR] = ~(i_a ^ i_b);
    o_exp[Y_NOT]  = ~i_a;
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Gate truth checker: compares observed gate outputs against the reference
// model, tracks operand coverage and error statistics, and issues a verdict
// when coverage completes or the run times out.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int ERR_W   = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic [6:0]       y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic [1:0]       fail_vec,
  output logic [6:0]       fail_mask
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_cov;
  logic [1:0]       r_fail_vec;
  logic [6:0]       r_fail_mask;
  logic             r_pass;
  logic [TO_W-1:0]  r_to_cnt;

  logic [6:0]       w_exp;
  logic [6:0]       w_diff;
  logic             w_mis;
  logic [1:0]       w_idx;
  logic             w_chk;
  logic             w_enter_run;
  logic [3:0]       w_cov_nxt;
  logic [ERR_W-1:0] w_err_nxt;
  logic             w_cov_full;
  logic             w_to_hit;

  gate_ref_model u_ref (
    .i_a   (a),
    .i_b   (b),
    .o_exp (w_exp)
  );

  // Per-cycle check of the presented vector and the resulting next statistics
  always_comb begin
    w_diff      = y ^ w_exp;
    w_mis       = |w_diff;
    w_idx       = {a, b};
    w_chk       = (r_state == ST_RUN) && vld;
    w_enter_run = (r_state != ST_RUN) && start;
    w_cov_nxt   = r_cov;
    if (w_chk) w_cov_nxt = r_cov | (4'b0001 << w_idx);
    w_err_nxt   = r_err;
    if (w_chk && w_mis && (r_err != '1)) w_err_nxt = r_err + 1'b1;
    w_cov_full  = (w_cov_nxt == 4'hF);
    w_to_hit    = (r_to_cnt == TO_LAST);
  end

  // Next-state logic; coverage completion and timeout both end a run
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_cov_full || w_to_hit) w_state_nxt = ST_DONE;
      ST_DONE: if (start) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Statistics: cleared on run entry, updated from checked vectors in RUN
  always_ff @(posedge clk) begin
    if (rst || w_enter_run) begin
      r_err       <= '0;
      r_cov       <= '0;
      r_fail_vec  <= '0;
      r_fail_mask <= '0;
      r_pass      <= 1'b0;
      r_to_cnt    <= '0;
    end else if (r_state == ST_RUN) begin
      r_cov <= w_cov_nxt;
      r_err <= w_err_nxt;
      // A zero error count means no mismatch has been seen yet this run
      if (w_chk && w_mis && (r_err == '0)) begin
        r_fail_vec  <= w_idx;
        r_fail_mask <= w_diff;
      end
      if (!w_to_hit) r_to_cnt <= r_to_cnt + 1'b1;
      // Verdict uses the statistics including this cycle's vector
      if (w_state_nxt == ST_DONE) r_pass <= w_cov_full && (w_err_nxt == '0);
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign cov       = r_cov;
  assign fail_vec  = r_fail_vec;
  assign fail_mask = r_fail_mask;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker (TIMEOUT=8, ERR_W=2).
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       vld = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [6:0] y = '0;
  logic       busy, done, pass;
  logic [1:0] err_cnt;
  logic [3:0] cov;
  logic [1:0] fail_vec;
  logic [6:0] fail_mask;

  int n_cmp = 0;
  int n_err = 0;

  // Correct y per {a,b}: {NOT a, XNOR, XOR, NOR, NAND, OR, AND}
  localparam logic [6:0] G00 = 7'b1101100;
  localparam logic [6:0] G01 = 7'b1010110;
  localparam logic [6:0] G10 = 7'b0010110;
  localparam logic [6:0] G11 = 7'b0100011;

  gate_truth_checker #(.TIMEOUT(8), .ERR_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .cov(cov),
    .fail_vec(fail_vec), .fail_mask(fail_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector for exactly one edge
  task automatic vec(input logic va, input logic vb, input logic [6:0] vy);
    vld = 1'b1; a = va; b = vb; y = vy;
    tick();
    vld = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, pass, err_cnt, cov, fail_vec, fail_mask} !== '0) begin
      n_err++; $display("FAIL reset_outs: got %h want 0",
        {busy, done, pass, err_cnt, cov, fail_vec, fail_mask});
    end
  endtask

  task automatic test_exhaustive_pass();
    do_start();
    n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL pass_busy: got %b want 10", {busy, done}); end
    vec(0, 0, G00); vec(0, 1, G01); vec(1, 0, G10);
    n_cmp++; if ({done, cov} !== 5'b0_0111) begin n_err++; $display("FAIL pass_partial: got %b want 00111", {done, cov}); end
    vec(1, 1, G11);
    n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL pass_done: got %b want 01", {busy, done}); end
    n_cmp++; if (cov !== 4'hF) begin n_err++; $display("FAIL pass_cov: got %h want f", cov); end
    n_cmp++; if ({pass, err_cnt} !== 3'b100) begin n_err++; $display("FAIL pass_verdict: got %b want 100", {pass, err_cnt}); end
  endtask

  task automatic test_faulty_xor();
    do_start();
    vec(1, 1, G11 ^ 7'b0010000);
    n_cmp++; if (err_cnt !== 2'd1) begin n_err++; $display("FAIL xor_err1: got %0d want 1", err_cnt); end
    vec(0, 0, G00); vec(0, 1, G01); vec(1, 0, G10);
    n_cmp++; if ({done, pass, err_cnt} !== 4'b1001) begin n_err++; $display("FAIL xor_verdict: got %b want 1001", {done, pass, err_cnt}); end
    n_cmp++; if (fail_vec !== 2'b11) begin n_err++; $display("FAIL xor_fail_vec: got %b want 11", fail_vec); end
    n_cmp++; if (fail_mask !== 7'b0010000) begin n_err++; $display("FAIL xor_fail_mask: got %b want 0010000", fail_mask); end
  endtask

  // Start from DONE with a simultaneous bad vector: stats clear, vector dropped
  task automatic test_restart_vld_ignored();
    start = 1'b1;
    vec(0, 0, 7'b0);
    start = 1'b0;
    n_cmp++; if ({busy, done, pass} !== 3'b100) begin n_err++; $display("FAIL rs_state: got %b want 100", {busy, done, pass}); end
    n_cmp++; if ({err_cnt, cov, fail_vec, fail_mask} !== '0) begin n_err++; $display("FAIL rs_clear: got %h want 0", {err_cnt, cov, fail_vec, fail_mask}); end
  endtask

  // Continues the run opened above: only the first mismatch is captured
  task automatic test_first_only();
    vec(1, 0, G10 ^ 7'b0000001);
    vec(0, 0, G00 ^ 7'b1000000);
    n_cmp++; if (err_cnt !== 2'd2) begin n_err++; $display("FAIL fo_err: got %0d want 2", err_cnt); end
    n_cmp++; if ({fail_vec, fail_mask} !== {2'b10, 7'b0000001}) begin n_err++; $display("FAIL fo_capture: got %b_%b want 10_0000001", fail_vec, fail_mask); end
    vec(0, 1, G01); vec(1, 1, G11);
    n_cmp++; if ({done, pass, cov} !== 6'b10_1111) begin n_err++; $display("FAIL fo_verdict: got %b want 101111", {done, pass, cov}); end
  endtask

  task automatic test_timeout();
    do_start();
    vec(0, 0, G00); vec(0, 1, G01);
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL to_early: got %b want 10", {busy, done}); end
    tick();
    n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL to_done: got %b want 01", {busy, done}); end
    n_cmp++; if ({cov, pass} !== 5'b0011_0) begin n_err++; $display("FAIL to_verdict: got %b want 00110", {cov, pass}); end
  endtask

  task automatic test_coincident();
    do_start();
    vec(0, 0, G00); vec(0, 1, G01); vec(1, 0, G10);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if ({busy, done, cov} !== 6'b10_0111) begin n_err++; $display("FAIL co_early: got %b want 100111", {busy, done, cov}); end
    vec(1, 1, G11);
    n_cmp++; if ({done, pass, cov} !== 6'b11_1111) begin n_err++; $display("FAIL co_verdict: got %b want 111111", {done, pass, cov}); end
  endtask

  task automatic test_saturation();
    do_start();
    for (int i = 0; i < 3; i++) vec(0, 0, 7'b0);
    n_cmp++; if (err_cnt !== 2'd3) begin n_err++; $display("FAIL sat_3: got %0d want 3", err_cnt); end
    vec(0, 0, 7'b0); vec(0, 0, 7'b0);
    n_cmp++; if (err_cnt !== 2'd3) begin n_err++; $display("FAIL sat_hold: got %0d want 3", err_cnt); end
    n_cmp++; if ({fail_vec, fail_mask} !== {2'b00, G00}) begin n_err++; $display("FAIL sat_capture: got %b_%b want 00_%b", fail_vec, fail_mask, G00); end
    tick(); tick(); tick();
    n_cmp++; if ({done, pass, err_cnt} !== 4'b1011) begin n_err++; $display("FAIL sat_verdict: got %b want 1011", {done, pass, err_cnt}); end
    do_start();
    n_cmp++; if ({busy, done, pass, err_cnt, cov, fail_vec, fail_mask} !== {1'b1, 17'b0}) begin
      n_err++; $display("FAIL sat_restart: got %h want %h",
        {busy, done, pass, err_cnt, cov, fail_vec, fail_mask}, {1'b1, 17'b0});
    end
  endtask

  // Assumes a run is already in progress (opened by the restart above)
  task automatic test_reset_mid_run();
    vec(0, 0, G00); vec(0, 1, G01);
    n_cmp++; if (cov !== 4'b0011) begin n_err++; $display("FAIL mr_cov: got %b want 0011", cov); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if ({busy, done, pass, err_cnt, cov, fail_vec, fail_mask} !== '0) begin
      n_err++; $display("FAIL mr_clear: got %h want 0", {busy, done, pass, err_cnt, cov, fail_vec, fail_mask});
    end
    vec(1, 0, G10); vec(1, 1, G11);
    tick();
    n_cmp++; if ({busy, done, cov} !== 6'b0) begin n_err++; $display("FAIL mr_idle_vld: got %b want 000000", {busy, done, cov}); end
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL rst_prio: got %b want 00", {busy, done}); end
  endtask

  initial begin
    test_reset();
    test_exhaustive_pass();
    test_faulty_xor();
    test_restart_vld_ignored();
    test_first_only();
    test_timeout();
    test_coincident();
    test_saturation();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
